sopc_run_ctrl: RTL and testbench
================================

// Module: sopc_run_ctrl
// PURPOSE
//  Run controller for the minimal SOPC in simulation and FPGA bring-up: replaces fixed reset delays and
//  hard-coded stop times. Sequences core reset, counts run cycles, detects the end-of-test write to a
//  TOHOST address (pass/fail plus code), and flags timeout or PC stall. Sits between the board/TB reset and
//  the openmips core and snoops the core's data-memory write port and fetch PC.
// PARAMETERS
//  RST_CYCLES    10            clocks core_rst_o stays high after rst falls (>=1)
//  MAX_CYCLES    150           run-cycle budget before TIMEOUT (>=2)
//  STALL_CYCLES  16            consecutive cycles with unchanged pc_i that count as a stall; 0 disables
//  CNT_W         32            width of the cycle counter
//  ADDR_W        32            data address width
//  TOHOST_ADDR   32'h0000_0100 word address whose write ends the test
//  HOLD_ON_DONE  1             1: core_rst_o re-asserts in terminal states (freezes core); 0: core keeps running
// PORTS
//  clk          in   1       system clock
//  rst          in   1       reset: one clock, reset is synchronous and active-high
//  pc_i         in   ADDR_W  core fetch PC
//  mem_we_i     in   1       core data-memory write strobe
//  mem_addr_i   in   ADDR_W  core data-memory address
//  mem_data_i   in   32      core data-memory write data
//  core_rst_o   out  1       reset to core/ROM/RAM, active-high
//  running_o    out  1       state RUN
//  done_o       out  1       any terminal state (PASS/FAIL/TIMEOUT)
//  pass_o       out  1       state PASS
//  fail_o       out  1       state FAIL
//  timeout_o    out  1       state TIMEOUT
//  code_o       out  32      result code (see BEHAVIOUR)
//  cycles_o     out  CNT_W   run cycles elapsed
// BEHAVIOUR
//  - All outputs registered. rst=1 at a clock edge: state=HOLD, rst_cnt=0, cycles=0, stall_cnt=0, code=0,
//    core_rst_o=1, all flags 0. rst asserted in any state (mid-run, terminal) restarts the full sequence.
//  - HOLD: rst_cnt increments each clock with rst=0; on the edge where rst_cnt==RST_CYCLES-1 -> RUN and
//    core_rst_o=0. So core_rst_o falls exactly RST_CYCLES edges after the first edge sampling rst=0.
//  - RUN: cycles +1 per clock (saturates at all-ones). Per edge, priority high->low:
//    1) mem_we_i && mem_addr_i==TOHOST_ADDR: mem_data_i==1 -> PASS, code=1; else -> FAIL, code=mem_data_i.
//    2) cycles==MAX_CYCLES-1 -> TIMEOUT, code=0.
//    3) STALL_CYCLES!=0 && stall_cnt==STALL_CYCLES-1 && pc_i==pc_q -> TIMEOUT, code=1.
//    stall_cnt: pc_i==pc_q -> +1, else 0; pc_q<=pc_i every RUN cycle; pc_q loaded on HOLD->RUN so the first
//    RUN cycle never counts as a stall hit.
//  - Writes outside RUN (HOLD, terminal) are ignored. TOHOST write and timeout in same cycle -> PASS/FAIL.
//  - Terminal states PASS/FAIL/TIMEOUT are sticky until rst; cycles and code frozen; exactly one of
//    pass_o/fail_o/timeout_o high, done_o high. core_rst_o=HOLD_ON_DONE on the edge of entry.
//  - Latency: flag outputs rise on the clock edge that samples the terminating event (1 cycle).
// TESTING
//  T1 rst high 3 clks, low: core_rst_o falls at 10th edge after rst low; running_o rises same edge; cycles_o=0.
//  T2 in RUN, write addr 0x100 data 1 at run cycle 40 -> pass_o=1, code_o=1, cycles_o=41, core_rst_o=1, frozen 20 clks.
//  T3 write 0x100 data 0x0000_0007 -> fail_o=1, code_o=7; later write 0x100 data 1 ignored (stays FAIL).
//  T4 no TOHOST write, pc_i toggling -> timeout_o=1, code_o=0, cycles_o=150; write on cycle 149 instead -> PASS.
//  T5 pc_i held constant 16 clks in RUN -> timeout_o=1, code_o=1; pc change at clk 15 resets count, no stall.
//  T6 rst pulsed 1 clk mid-RUN and in PASS -> all flags 0, cycles 0, core_rst_o=1 for 10 more clks, rerun OK.

Source files
------------

// File: rtl/sopc_run_ctrl.sv
// Run controller for the minimal SOPC: sequences the core reset, counts run cycles and
// ends the run on a TOHOST write (pass/fail), an exhausted cycle budget or a stalled fetch PC.
module sopc_run_ctrl #(
   parameter int unsigned       RST_CYCLES   = 10,
   parameter int unsigned       MAX_CYCLES   = 150,
   parameter int unsigned       STALL_CYCLES = 16,
   parameter int unsigned       CNT_W        = 32,
   parameter int unsigned       ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h100,
   parameter bit                HOLD_ON_DONE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_data_i,
   output logic              core_rst_o,
   output logic              running_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              fail_o,
   output logic              timeout_o,
   output logic [31:0]       code_o,
   output logic [CNT_W-1:0]  cycles_o
);

   localparam int unsigned RST_W   = (RST_CYCLES > 1)   ? $clog2(RST_CYCLES)   : 1;
   localparam int unsigned STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
   localparam bit          STALL_EN = (STALL_CYCLES != 0);

   localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

   typedef enum logic [2:0] {
      S_HOLD,
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT
   } state_t;

   state_t             state_q, state_d;
   logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0]   cycles_q, cycles_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [31:0]        code_q, code_d;
   logic               core_rst_q, core_rst_d;
   logic               running_q, running_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic               fail_q, fail_d;
   logic               timeout_q, timeout_d;

   logic tohost_hit;
   logic pc_same;

   assign tohost_hit = mem_we_i && (mem_addr_i == TOHOST_ADDR);
   assign pc_same    = (pc_i == pc_q);

   // NOTE: every signal assigned here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      cycles_d    = cycles_q;
      stall_cnt_d = stall_cnt_q;
      pc_d        = pc_q;
      code_d      = code_q;
      core_rst_d  = core_rst_q;

      unique case (state_q)
         S_HOLD: begin
            core_rst_d = 1'b1;
            if (rst_cnt_q == RST_LAST) begin
               state_d     = S_RUN;
               core_rst_d  = 1'b0;
               pc_d        = pc_i;
               stall_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end

         S_RUN: begin
            if (cycles_q != '1) begin
               cycles_d = cycles_q + 1'b1;
            end
            pc_d = pc_i;
            if (STALL_EN) begin
               stall_cnt_d = pc_same ? stall_cnt_q + 1'b1 : '0;
            end

            // TOHOST write wins over both timeout sources on the same edge.
            if (tohost_hit) begin
               core_rst_d = HOLD_ON_DONE;
               if (mem_data_i == 32'd1) begin
                  state_d = S_PASS;
                  code_d  = 32'd1;
               end else begin
                  state_d = S_FAIL;
                  code_d  = mem_data_i;
               end
            end else if (cycles_q == CYC_LAST) begin
               state_d    = S_TIMEOUT;
               code_d     = 32'd0;
               core_rst_d = HOLD_ON_DONE;
            end else if (STALL_EN && (stall_cnt_q == STALL_LAST) && pc_same) begin
               state_d    = S_TIMEOUT;
               code_d     = 32'd1;
               core_rst_d = HOLD_ON_DONE;
            end
         end

         // Terminal states hold everything until the next rst.
         S_PASS, S_FAIL, S_TIMEOUT: begin
            state_d = state_q;
         end

         default: begin
            state_d = S_HOLD;
         end
      endcase

      running_d = (state_d == S_RUN);
      pass_d    = (state_d == S_PASS);
      fail_d    = (state_d == S_FAIL);
      timeout_d = (state_d == S_TIMEOUT);
      done_d    = pass_d || fail_d || timeout_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_HOLD;
         rst_cnt_q   <= '0;
         cycles_q    <= '0;
         stall_cnt_q <= '0;
         pc_q        <= '0;
         code_q      <= '0;
         core_rst_q  <= 1'b1;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         cycles_q    <= cycles_d;
         stall_cnt_q <= stall_cnt_d;
         pc_q        <= pc_d;
         code_q      <= code_d;
         core_rst_q  <= core_rst_d;
         running_q   <= running_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         timeout_q   <= timeout_d;
      end
   end

   assign core_rst_o = core_rst_q;
   assign running_o  = running_q;
   assign done_o     = done_q;
   assign pass_o     = pass_q;
   assign fail_o     = fail_q;
   assign timeout_o  = timeout_q;
   assign code_o     = code_q;
   assign cycles_o   = cycles_q;

   // At most one result flag, and done exactly when one is set.
   a_one_result: assert property (@(posedge clk) disable iff (rst)
      $onehot0({pass_q, fail_q, timeout_q}));
   a_done_match: assert property (@(posedge clk) disable iff (rst)
      done_q == (pass_q || fail_q || timeout_q));

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed bench for sopc_run_ctrl with default parameters: reset sequencing, pass/fail,
// cycle-budget and PC-stall timeouts, and restart by rst from run and terminal states.
module tb_sopc_run_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = 32'h0000_1000;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_data = '0;
   logic        core_rst, running, done, pass, fail, timeout;
   logic [31:0] code;
   logic [31:0] cycles;
   logic [5:0]  flags;

   int n_checks = 0;
   int n_fails  = 0;
   bit pc_walk  = 1'b1;

   // {core_rst, running, done, pass, fail, timeout}
   localparam logic [5:0] F_HOLD = 6'b100000;
   localparam logic [5:0] F_RUN  = 6'b010000;
   localparam logic [5:0] F_PASS = 6'b101100;
   localparam logic [5:0] F_FAIL = 6'b101010;
   localparam logic [5:0] F_TOUT = 6'b101001;

   assign flags = {core_rst, running, done, pass, fail, timeout};

   always #5 clk = ~clk;

   sopc_run_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .pc_i       (pc),
      .mem_we_i   (mem_we),
      .mem_addr_i (mem_addr),
      .mem_data_i (mem_data),
      .core_rst_o (core_rst),
      .running_o  (running),
      .done_o     (done),
      .pass_o     (pass),
      .fail_o     (fail),
      .timeout_o  (timeout),
      .code_o     (code),
      .cycles_o   (cycles)
   );

   // One clock edge; outputs are sampled and inputs changed 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
      if (pc_walk) pc = pc + 32'd4;
   endtask

   task automatic write_mem(input logic [31:0] a, input logic [31:0] d);
      mem_we   = 1'b1;
      mem_addr = a;
      mem_data = d;
      tick();
      mem_we   = 1'b0;
   endtask

   // One-clock rst pulse, then the 10 edges of core reset; ends with cycles_o == 0 in RUN.
   task automatic start_run();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (flags !== F_HOLD) begin
         n_fails++;
         $display("FAIL reset_flags: got %b want %b", flags, F_HOLD);
      end
      n_checks++;
      if (cycles !== 32'd0 || code !== 32'd0) begin
         n_fails++;
         $display("FAIL reset_counters: cycles %0d code %0d want 0 0", cycles, code);
      end
      rst = 1'b0;
      // A TOHOST write while the core is still held must be ignored.
      mem_we   = 1'b1;
      mem_addr = 32'h100;
      mem_data = 32'd1;
      repeat (9) tick();
      mem_we = 1'b0;
      n_checks++;
      if (flags !== F_HOLD) begin
         n_fails++;
         $display("FAIL hold_9th_edge: got %b want %b", flags, F_HOLD);
      end
      tick();
      n_checks++;
      if (flags !== F_RUN) begin
         n_fails++;
         $display("FAIL release_10th_edge: got %b want %b", flags, F_RUN);
      end
      n_checks++;
      if (cycles !== 32'd0) begin
         n_fails++;
         $display("FAIL release_cycles: got %0d want 0", cycles);
      end
   endtask

   task automatic test_pass();
      pc_walk = 1'b1;
      start_run();
      repeat (20) tick();
      write_mem(32'h104, 32'd1);
      n_checks++;
      if (flags !== F_RUN || cycles !== 32'd21) begin
         n_fails++;
         $display("FAIL other_addr_ignored: flags %b cycles %0d want %b 21", flags, cycles, F_RUN);
      end
      repeat (19) tick();
      write_mem(32'h100, 32'd1);
      n_checks++;
      if (flags !== F_PASS) begin
         n_fails++;
         $display("FAIL pass_flags: got %b want %b", flags, F_PASS);
      end
      n_checks++;
      if (code !== 32'd1 || cycles !== 32'd41) begin
         n_fails++;
         $display("FAIL pass_values: code %0d cycles %0d want 1 41", code, cycles);
      end
      repeat (20) tick();
      n_checks++;
      if (flags !== F_PASS || code !== 32'd1 || cycles !== 32'd41) begin
         n_fails++;
         $display("FAIL pass_frozen: flags %b code %0d cycles %0d want %b 1 41", flags, code, cycles, F_PASS);
      end
   endtask

   task automatic test_fail();
      pc_walk = 1'b1;
      start_run();
      repeat (5) tick();
      write_mem(32'h100, 32'h0000_0007);
      n_checks++;
      if (flags !== F_FAIL || code !== 32'd7 || cycles !== 32'd6) begin
         n_fails++;
         $display("FAIL fail_entry: flags %b code %0d cycles %0d want %b 7 6", flags, code, cycles, F_FAIL);
      end
      repeat (3) tick();
      write_mem(32'h100, 32'd1);
      tick();
      n_checks++;
      if (flags !== F_FAIL || code !== 32'd7 || cycles !== 32'd6) begin
         n_fails++;
         $display("FAIL fail_sticky: flags %b code %0d cycles %0d want %b 7 6", flags, code, cycles, F_FAIL);
      end
   endtask

   task automatic test_timeout();
      pc_walk = 1'b1;
      start_run();
      repeat (149) tick();
      n_checks++;
      if (flags !== F_RUN || cycles !== 32'd149) begin
         n_fails++;
         $display("FAIL budget_edge_minus1: flags %b cycles %0d want %b 149", flags, cycles, F_RUN);
      end
      tick();
      n_checks++;
      if (flags !== F_TOUT || code !== 32'd0 || cycles !== 32'd150) begin
         n_fails++;
         $display("FAIL budget_timeout: flags %b code %0d cycles %0d want %b 0 150", flags, code, cycles, F_TOUT);
      end
      repeat (5) tick();
      n_checks++;
      if (flags !== F_TOUT || cycles !== 32'd150) begin
         n_fails++;
         $display("FAIL timeout_frozen: flags %b cycles %0d want %b 150", flags, cycles, F_TOUT);
      end
      // TOHOST write on the very edge the budget runs out: the write wins.
      start_run();
      repeat (149) tick();
      write_mem(32'h100, 32'd1);
      n_checks++;
      if (flags !== F_PASS || code !== 32'd1 || cycles !== 32'd150) begin
         n_fails++;
         $display("FAIL write_beats_timeout: flags %b code %0d cycles %0d want %b 1 150", flags, code, cycles, F_PASS);
      end
   endtask

   task automatic test_stall();
      pc_walk = 1'b1;
      start_run();
      repeat (5) tick();
      pc_walk = 1'b0;
      repeat (16) tick();
      n_checks++;
      if (flags !== F_RUN) begin
         n_fails++;
         $display("FAIL stall_not_yet: got %b want %b", flags, F_RUN);
      end
      tick();
      n_checks++;
      if (flags !== F_TOUT || code !== 32'd1 || cycles !== 32'd22) begin
         n_fails++;
         $display("FAIL stall_timeout: flags %b code %0d cycles %0d want %b 1 22", flags, code, cycles, F_TOUT);
      end
      // A PC change after 15 constant edges restarts the stall count.
      pc_walk = 1'b1;
      start_run();
      repeat (5) tick();
      pc_walk = 1'b0;
      repeat (15) tick();
      pc = pc + 32'd4;
      repeat (16) tick();
      n_checks++;
      if (flags !== F_RUN || cycles !== 32'd36) begin
         n_fails++;
         $display("FAIL stall_count_restart: flags %b cycles %0d want %b 36", flags, cycles, F_RUN);
      end
      tick();
      n_checks++;
      if (flags !== F_TOUT || code !== 32'd1 || cycles !== 32'd37) begin
         n_fails++;
         $display("FAIL stall_after_restart: flags %b code %0d cycles %0d want %b 1 37", flags, code, cycles, F_TOUT);
      end
   endtask

   task automatic test_restart();
      pc_walk = 1'b1;
      start_run();
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (flags !== F_HOLD || cycles !== 32'd0 || code !== 32'd0) begin
         n_fails++;
         $display("FAIL rst_mid_run: flags %b cycles %0d code %0d want %b 0 0", flags, cycles, code, F_HOLD);
      end
      repeat (9) tick();
      n_checks++;
      if (flags !== F_HOLD) begin
         n_fails++;
         $display("FAIL rerun_hold: got %b want %b", flags, F_HOLD);
      end
      tick();
      n_checks++;
      if (flags !== F_RUN || cycles !== 32'd0) begin
         n_fails++;
         $display("FAIL rerun_release: flags %b cycles %0d want %b 0", flags, cycles, F_RUN);
      end
      repeat (2) tick();
      write_mem(32'h100, 32'd1);
      n_checks++;
      if (flags !== F_PASS || cycles !== 32'd3) begin
         n_fails++;
         $display("FAIL rerun_pass: flags %b cycles %0d want %b 3", flags, cycles, F_PASS);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (flags !== F_HOLD || cycles !== 32'd0 || code !== 32'd0) begin
         n_fails++;
         $display("FAIL rst_in_pass: flags %b cycles %0d code %0d want %b 0 0", flags, cycles, code, F_HOLD);
      end
      repeat (10) tick();
      n_checks++;
      if (flags !== F_RUN) begin
         n_fails++;
         $display("FAIL rerun_after_pass: got %b want %b", flags, F_RUN);
      end
      repeat (4) tick();
      write_mem(32'h100, 32'h0000_00a5);
      n_checks++;
      if (flags !== F_FAIL || code !== 32'h0000_00a5 || cycles !== 32'd5) begin
         n_fails++;
         $display("FAIL rerun_fail: flags %b code %h cycles %0d want %b a5 5", flags, code, cycles, F_FAIL);
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_timeout();
      test_stall();
      test_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
